// File: rtl/led_pattern_pkg.sv
// ============================================================================
// Module      : led_pattern_pkg
// Description : Frame geometry, lock signature, state and segment encodings
//               for the 8-LED blinky frame tracker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_pattern_pkg;

    localparam int         FRAME_LEN        = 106;
    localparam logic [6:0] LAST_STEP        = 7'd105;
    localparam logic [6:0] LOCK_STEP        = 7'd2;

    localparam logic [6:0] SEG_FILL_START   = 7'd1;
    localparam logic [6:0] SEG_DRAIN_START  = 7'd9;
    localparam logic [6:0] SEG_WALKDN_START = 7'd18;
    localparam logic [6:0] SEG_WALKUP_START = 7'd26;
    localparam logic [6:0] SEG_GAP_START    = 7'd34;
    localparam logic [6:0] SEG_STROBE_START = 7'd35;
    localparam logic [6:0] SEG_NIBBLE_START = 7'd56;
    localparam logic [6:0] SEG_FINAL_START  = 7'd73;

    localparam logic [7:0] SIG0 = 8'h00;
    localparam logic [7:0] SIG1 = 8'h80;
    localparam logic [7:0] SIG2 = 8'hC0;

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [2:0] SEG_IDLE   = 3'd0;
    localparam logic [2:0] SEG_FILL   = 3'd1;
    localparam logic [2:0] SEG_DRAIN  = 3'd2;
    localparam logic [2:0] SEG_WALKDN = 3'd3;
    localparam logic [2:0] SEG_WALKUP = 3'd4;
    localparam logic [2:0] SEG_STROBE = 3'd5;
    localparam logic [2:0] SEG_NIBBLE = 3'd6;
    localparam logic [2:0] SEG_FINAL  = 3'd7;

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

    // LED numbering runs MSB-first: 8'h80 is position 0, 8'h01 is position 7.
    function automatic logic [2:0] onehot_pos(input logic [7:0] v);
        logic [2:0] pos;
        pos = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) pos = 3'(7 - i);
        end
        return pos;
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_pattern_expect.sv
// ============================================================================
// Module      : led_pattern_expect
// Description : Combinational lookup of the expected LED pattern and segment
//               for a frame step; even final-segment steps accept any one-hot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pattern_expect
    import led_pattern_pkg::*;
(
    input  logic [6:0] step,
    output logic [7:0] exp,
    output logic       any_onehot,
    output logic [2:0] seg
);

    always_comb begin
        exp        = 8'h00;
        any_onehot = 1'b0;
        seg        = SEG_IDLE;
        if (step < SEG_FILL_START) begin
            exp = 8'h00;
        end else if (step < SEG_DRAIN_START) begin
            seg = SEG_FILL;
            exp = 8'hFF << (7'd8 - step);
        end else if (step < SEG_WALKDN_START) begin
            seg = SEG_DRAIN;
            exp = 8'hFF << (step - SEG_DRAIN_START);
        end else if (step < SEG_WALKUP_START) begin
            seg = SEG_WALKDN;
            exp = 8'h80 >> (step - SEG_WALKDN_START);
        end else if (step < SEG_GAP_START) begin
            seg = SEG_WALKUP;
            exp = 8'h01 << (step - SEG_WALKUP_START);
        end else if (step < SEG_STROBE_START) begin
            // single blank step between walk-up and strobe is reported as idle
            seg = SEG_IDLE;
            exp = 8'h00;
        end else if (step < SEG_NIBBLE_START) begin
            seg = SEG_STROBE;
            exp = step[0] ? 8'h00 : 8'hFF;
        end else if (step < SEG_FINAL_START) begin
            seg = SEG_NIBBLE;
            exp = step[0] ? 8'hF0 : 8'h0F;
        end else if (step <= LAST_STEP) begin
            seg        = SEG_FINAL;
            exp        = 8'h00;
            any_onehot = ~step[0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_pattern_tracker.sv
// ============================================================================
// Module      : led_pattern_tracker
// Description : Locks onto the 106-step LED frame and reports step, segment,
//               mismatches, frame completion and a saturating error count.
//               Define LEDTRK_FINALPOS_EN to capture the final-segment LED.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pattern_tracker
    import led_pattern_pkg::*;
#(
    parameter int MISS_LIMIT = 3,
    parameter int ERR_W      = 8
) (
    input  logic             clk25,
    input  logic             rst,
    input  logic             sample_en,
    input  logic [7:0]       led_in,
    output logic             locked,
    output logic [6:0]       step,
    output logic [2:0]       seg_id,
    output logic             mismatch,
    output logic             frame_done,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       final_pos
);

    localparam int c_MISS_W = $clog2(MISS_LIMIT + 1);

    state_t              r_state;
    state_t              w_state_nx;
    logic [1:0][7:0]     r_hist;
    logic [6:0]          r_step;
    logic [2:0]          r_seg;
    logic [c_MISS_W-1:0] r_miss;
    logic [ERR_W-1:0]    r_err;
    logic                r_mismatch;
    logic                r_frame_done;

    logic [6:0]          w_step_nx;
    logic [7:0]          w_exp;
    logic                w_any_oh;
    logic [2:0]          w_seg;
    logic                w_match;
    logic                w_sig_seen;
    logic [c_MISS_W-1:0] w_miss_nx;
    logic                w_miss_limit;
    logic                w_hunt_smp;
    logic                w_lock_smp;
    logic                w_acquire;
    logic                w_drop;

    assign w_step_nx = (r_step == LAST_STEP) ? 7'd0 : r_step + 7'd1;

    led_pattern_expect u_expect (
        .step       (w_step_nx),
        .exp        (w_exp),
        .any_onehot (w_any_oh),
        .seg        (w_seg)
    );

    assign w_match      = w_any_oh ? is_onehot(led_in) : (led_in == w_exp);
    assign w_sig_seen   = (r_hist[1] == SIG0) && (r_hist[0] == SIG1) && (led_in == SIG2);
    assign w_miss_nx    = r_miss + c_MISS_W'(1);
    assign w_miss_limit = !w_match && (w_miss_nx == c_MISS_W'(MISS_LIMIT));

    always_ff @(posedge clk25) begin
        if (rst) r_state <= ST_HUNT;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        if (sample_en) begin
            case (r_state)
                ST_HUNT:   if (w_sig_seen)   w_state_nx = ST_LOCKED;
                ST_LOCKED: if (w_miss_limit) w_state_nx = ST_HUNT;
                default:                     w_state_nx = ST_HUNT;
            endcase
        end
    end

    always_comb begin
        w_hunt_smp = sample_en && (r_state == ST_HUNT);
        w_lock_smp = sample_en && (r_state == ST_LOCKED);
        w_acquire  = w_hunt_smp && w_sig_seen;
        w_drop     = w_lock_smp && w_miss_limit;
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            r_hist       <= '0;
            r_step       <= 7'd0;
            r_seg        <= SEG_IDLE;
            r_miss       <= '0;
            r_err        <= '0;
            r_mismatch   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_mismatch   <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_hunt_smp) begin
                r_hist <= {r_hist[0], led_in};
                if (w_acquire) begin
                    r_step <= LOCK_STEP;
                    r_seg  <= SEG_FILL;
                    r_miss <= '0;
                end
            end
            if (w_lock_smp) begin
                // the step keeps advancing through errors; realignment only via HUNT
                r_step       <= w_step_nx;
                r_seg        <= w_drop ? SEG_IDLE : w_seg;
                r_frame_done <= (w_step_nx == 7'd0);
                if (!w_match) begin
                    r_mismatch <= 1'b1;
                    if (r_err != {ERR_W{1'b1}}) r_err <= r_err + ERR_W'(1);
                    r_miss <= w_drop ? '0 : w_miss_nx;
                end else begin
                    r_miss <= '0;
                end
                if (w_drop) r_hist <= '0;
            end
        end
    end

    assign locked     = (r_state == ST_LOCKED);
    assign step       = r_step;
    assign seg_id     = r_seg;
    assign mismatch   = r_mismatch;
    assign frame_done = r_frame_done;
    assign err_cnt    = r_err;

`ifdef LEDTRK_FINALPOS_EN
    logic [2:0] r_final_pos;

    always_ff @(posedge clk25) begin
        if (rst) begin
            r_final_pos <= 3'd0;
        end else if (w_lock_smp && w_match && w_any_oh) begin
            r_final_pos <= onehot_pos(led_in);
        end
    end

    assign final_pos = r_final_pos;
`else
    assign final_pos = 3'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_tracker.sv
// ============================================================================
// Module      : tb_led_pattern_tracker
// Description : Randomised scoreboard bench for led_pattern_tracker against a
//               table-driven frame model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_pattern_tracker;

    logic       clk25 = 1'b0;
    logic       rst = 1'b0;
    logic       sample_en = 1'b0;
    logic [7:0] led_in = 8'h00;
    logic       locked;
    logic [6:0] step;
    logic [2:0] seg_id;
    logic       mismatch;
    logic       frame_done;
    logic [7:0] err_cnt;
    logic [2:0] final_pos;

    led_pattern_tracker #(.MISS_LIMIT(3), .ERR_W(8)) dut (
        .clk25      (clk25),
        .rst        (rst),
        .sample_en  (sample_en),
        .led_in     (led_in),
        .locked     (locked),
        .step       (step),
        .seg_id     (seg_id),
        .mismatch   (mismatch),
        .frame_done (frame_done),
        .err_cnt    (err_cnt),
        .final_pos  (final_pos)
    );

    always #5 clk25 = ~clk25;

    typedef struct {
        logic       locked;
        logic [6:0] step;
        logic [2:0] seg;
        logic       mm;
        logic       fd;
        logic [7:0] err;
        logic [2:0] fp;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         errors = 0;
    int         checks = 0;
    bit         drv_flag = 1'b0;
    bit         pend = 1'b0;
    bit         armed = 1'b0;

    logic [7:0] pat[106];
    bit         dc[106];
    int         segt[106];

    bit         m_locked;
    int         m_step;
    logic [7:0] m_hist[$];
    int         m_miss;
    int         m_err;
    int         m_fp;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic build_tables();
        for (int s = 0; s < 106; s++) begin
            dc[s] = 1'b0;
            if (s == 0)       begin pat[s] = 8'h00; segt[s] = 0; end
            else if (s <= 8)  begin pat[s] = 8'(((1 << s) - 1) << (8 - s)); segt[s] = 1; end
            else if (s <= 17) begin pat[s] = 8'(((1 << (17 - s)) - 1) << (s - 9)); segt[s] = 2; end
            else if (s <= 25) begin pat[s] = 8'(1 << (25 - s)); segt[s] = 3; end
            else if (s <= 33) begin pat[s] = 8'(1 << (s - 26)); segt[s] = 4; end
            else if (s == 34) begin pat[s] = 8'h00; segt[s] = 0; end
            else if (s <= 55) begin pat[s] = (s % 2) ? 8'h00 : 8'hFF; segt[s] = 5; end
            else if (s <= 72) begin pat[s] = (s % 2) ? 8'hF0 : 8'h0F; segt[s] = 6; end
            else begin pat[s] = 8'h00; dc[s] = (s % 2 == 0); segt[s] = 7; end
        end
    endtask

    task automatic clear_hist();
        m_hist.delete();
        repeat (3) m_hist.push_back(8'h00);
    endtask

    task automatic model_step(input bit en, input logic [7:0] v, input bit r, output exp_t e);
        bit mm, fd, ok;
        mm = 1'b0;
        fd = 1'b0;
        if (r) begin
            m_locked = 1'b0; m_step = 0; m_miss = 0; m_err = 0; m_fp = 0;
            clear_hist();
        end else if (en) begin
            if (!m_locked) begin
                m_hist.push_back(v);
                void'(m_hist.pop_front());
                if (m_hist[0] == 8'h00 && m_hist[1] == 8'h80 && m_hist[2] == 8'hC0) begin
                    m_locked = 1'b1;
                    m_step = 2;
                    m_miss = 0;
                end
            end else begin
                m_step = (m_step + 1) % 106;
                fd = (m_step == 0);
                ok = dc[m_step] ? ($countones(v) == 1) : (v == pat[m_step]);
                if (!ok) begin
                    mm = 1'b1;
                    if (m_err < 255) m_err++;
                    m_miss++;
                end else begin
                    m_miss = 0;
                end
`ifdef LEDTRK_FINALPOS_EN
                if (ok && dc[m_step]) begin
                    for (int i = 0; i < 8; i++) if (v[i]) m_fp = 7 - i;
                end
`endif
                if (m_miss >= 3) begin
                    m_locked = 1'b0;
                    m_miss = 0;
                    clear_hist();
                end
            end
        end
        e.locked = m_locked;
        e.step   = 7'(m_step);
        e.seg    = m_locked ? 3'(segt[m_step]) : 3'd0;
        e.mm     = mm;
        e.fd     = fd;
        e.err    = 8'(m_err);
        e.fp     = 3'(m_fp);
    endtask

    task automatic cyc(input bit en, input logic [7:0] v, input bit r);
        exp_t e;
        sample_en = en;
        led_in    = v;
        rst       = r;
        if (en || r) begin
            model_step(en, v, r, e);
            sb_q.push_back(e);
            drv_flag = 1'b1;
        end else begin
            drv_flag = 1'b0;
        end
        @(posedge clk25);
        #1;
        sample_en = 1'b0;
        rst       = 1'b0;
        drv_flag  = 1'b0;
    endtask

    function automatic logic [7:0] good_val(input int s);
        return dc[s] ? 8'(8'h01 << $urandom_range(0, 7)) : pat[s];
    endfunction

    function automatic logic [7:0] bad_val(input int s);
        logic [7:0] nonhot[4];
        nonhot[0] = 8'h00; nonhot[1] = 8'h03; nonhot[2] = 8'hFF; nonhot[3] = 8'h81;
        if (dc[s]) return nonhot[$urandom_range(0, 3)];
        return pat[s] ^ 8'($urandom_range(1, 255));
    endfunction

    task automatic send_val(input logic [7:0] v);
        if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) cyc(1'b0, 8'($urandom), 1'b0);
        end
        cyc(1'b1, v, 1'b0);
    endtask

    task automatic send_step(input int s, input bit corrupt);
        send_val(corrupt ? bad_val(s) : good_val(s));
    endtask

    task automatic send_frame(input int from, input int to);
        for (int s = from; s <= to; s++) send_step(s, 1'b0);
    endtask

    always @(posedge clk25) pend <= drv_flag;

    always @(negedge clk25) begin
        if (pend) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("locked", locked, mon_e.locked);
                chk("step", step, mon_e.step);
                chk("seg_id", seg_id, mon_e.seg);
                chk("mismatch", mismatch, mon_e.mm);
                chk("frame_done", frame_done, mon_e.fd);
                chk("err_cnt", err_cnt, mon_e.err);
                chk("final_pos", final_pos, mon_e.fp);
            end
        end else if (armed) begin
            chk("idle_mismatch", mismatch, 32'd0);
            chk("idle_frame_done", frame_done, 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [2:0] fp_exp[5];
        logic [7:0] fin_v[5];
        build_tables();
        clear_hist();

        // reset state
        cyc(1'b0, 8'h00, 1'b1);
        armed = 1'b1;
        cyc(1'b0, 8'h00, 1'b1);
        @(negedge clk25);
        chk("rst_locked", locked, 32'd0);
        chk("rst_err", err_cnt, 32'd0);
        chk("rst_step", step, 32'd0);

        // clean frames from step 0
        send_frame(0, 105);
        send_frame(0, 105);
        @(negedge clk25);
        chk("clean_locked", locked, 32'd1);
        chk("clean_err", err_cnt, 32'd0);

        // mid-frame start: no lock until next frame's signature
        cyc(1'b0, 8'h00, 1'b1);
        send_frame(40, 105);
        @(negedge clk25);
        chk("midframe_hunt", locked, 32'd0);
        send_frame(0, 2);
        @(negedge clk25);
        chk("midframe_lock", locked, 32'd1);
        chk("midframe_step", step, 32'd2);
        send_frame(3, 105);

        // single corruption
        for (int s = 0; s < 106; s++) send_step(s, s == 20);
        @(negedge clk25);
        chk("single_err", err_cnt, 32'd1);
        chk("single_locked", locked, 32'd1);

        // three consecutive corruptions drop lock, relock next frame
        for (int s = 0; s < 106; s++) begin
            send_step(s, s >= 40 && s <= 42);
            if (s == 42) begin
                @(negedge clk25);
                chk("drop_locked", locked, 32'd0);
            end
        end
        send_frame(0, 105);
        @(negedge clk25);
        chk("relock", locked, 32'd1);

        // reset together with sample_en
        send_frame(0, 49);
        cyc(1'b1, pat[50], 1'b1);
        @(negedge clk25);
        chk("rst_en_locked", locked, 32'd0);
        chk("rst_en_step", step, 32'd0);
        chk("rst_en_err", err_cnt, 32'd0);
        send_frame(51, 105);
        send_frame(0, 105);

        // final segment captures and odd-step one-hot error
        fin_v[0] = 8'h20; fin_v[1] = 8'h02; fin_v[2] = 8'h80; fin_v[3] = 8'h10; fin_v[4] = 8'h04;
`ifdef LEDTRK_FINALPOS_EN
        fp_exp[0] = 3'd2; fp_exp[1] = 3'd6; fp_exp[2] = 3'd0; fp_exp[3] = 3'd3; fp_exp[4] = 3'd5;
`else
        for (int i = 0; i < 5; i++) fp_exp[i] = 3'd0;
`endif
        send_frame(0, 73);
        for (int s = 74; s <= 83; s++) begin
            if (s % 2 == 0) begin
                send_val(fin_v[(s - 74) / 2]);
                @(negedge clk25);
                chk("final_pos_dir", final_pos, fp_exp[(s - 74) / 2]);
            end else if (s == 75) begin
                send_val(8'h01);
                @(negedge clk25);
                chk("odd_onehot_mm", mismatch, 32'd1);
            end else begin
                send_step(s, 1'b0);
            end
        end
        send_frame(84, 105);

        // alternate corruptions keep lock and drive err_cnt to saturation
        for (int f = 0; f < 6; f++) begin
            for (int s = 0; s < 106; s++) send_step(s, (s % 2 == 1) && s >= 3);
        end
        @(negedge clk25);
        chk("sat_err", err_cnt, 32'd255);
        chk("sat_locked", locked, 32'd1);

        repeat (3) cyc(1'b0, 8'h00, 1'b0);
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
